// File: rtl/mux_sel_ctrl.sv
// rtl/mux_sel_ctrl.sv - debounced / auto-toggling select generator for the nibble mux array
//
// Produces the select line for the 2:1 nibble multiplexer array. A clean
// pushbutton press toggles SEL (manual mode). With the mode switch set, SEL
// also alternates every AUTO_PERIOD cycles (auto mode).
//
// Ports:
//   CLOCK_50   in   system clock, rising edge
//   RESET_N    in   asynchronous active-low reset, synchronous release
//   KEY_IN     in   raw pushbutton, active-low, asynchronous to CLOCK_50
//   MODE       in   raw slide switch, 0 = manual, 1 = auto, asynchronous
//   SEL        out  mux select, 0 = low nibble, 1 = high nibble
//   SEL_PULSE  out  one-cycle strobe on every SEL change
//   PRESS_CNT  out  accepted press count, wraps 255 -> 0

module mux_sel_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int AUTO_PERIOD     = 50000000,
    parameter int CNT_W           = 26
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       KEY_IN,
    input  logic       MODE,
    output logic       SEL,
    output logic       SEL_PULSE,
    output logic [7:0] PRESS_CNT
);

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(AUTO_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } db_state_t;

    // synchronisers
    logic key_meta;
    logic key_s;
    logic mode_meta;
    logic mode_s;

    // debounce
    db_state_t        state;
    db_state_t        state_nxt;
    logic [CNT_W-1:0] db_cnt;
    logic [CNT_W-1:0] db_cnt_nxt;
    logic             press_accept;

    // auto period
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] per_cnt_nxt;
    logic             auto_expire;
    logic             toggle;

    // The key idles high (released) and the switch idles in manual mode, so
    // reset preloads the synchronisers with those levels: leaving reset with
    // the key already held then looks like a fresh fall and is debounced
    // normally instead of producing an instant toggle.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            key_meta  <= 1'b1;
            key_s     <= 1'b1;
            mode_meta <= 1'b0;
            mode_s    <= 1'b0;
        end else begin
            key_meta  <= KEY_IN;
            key_s     <= key_meta;
            mode_meta <= MODE;
            mode_s    <= mode_meta;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state  <= ST_RELEASED;
            db_cnt <= '0;
        end else begin
            state  <= state_nxt;
            db_cnt <= db_cnt_nxt;
        end
    end

    // A level is accepted only after it has been seen continuously; any
    // opposite sample falls straight back to the previous stable state.
    always_comb begin
        state_nxt    = state;
        db_cnt_nxt   = db_cnt;
        press_accept = 1'b0;
        case (state)
            ST_RELEASED: begin
                if (!key_s) begin
                    state_nxt  = ST_PRESS_WAIT;
                    db_cnt_nxt = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (key_s) begin
                    state_nxt = ST_RELEASED;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt    = ST_HELD;
                    press_accept = 1'b1;
                end else begin
                    db_cnt_nxt = db_cnt + CNT_W'(1);
                end
            end
            ST_HELD: begin
                if (key_s) begin
                    state_nxt  = ST_RELEASE_WAIT;
                    db_cnt_nxt = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (!key_s) begin
                    state_nxt = ST_HELD;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt = ST_RELEASED;
                end else begin
                    db_cnt_nxt = db_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt  = ST_RELEASED;
                db_cnt_nxt = '0;
            end
        endcase
    end

    // per_cnt sits at 0 in manual mode, so entering auto mode always starts a
    // full period. A press restarts the period so the next auto toggle comes
    // a full period after the manual one; a press coinciding with expiry is a
    // single toggle.
    always_comb begin
        auto_expire = mode_s && (per_cnt == PER_LAST);
        toggle      = press_accept || auto_expire;
        if (toggle || !mode_s) begin
            per_cnt_nxt = '0;
        end else begin
            per_cnt_nxt = per_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            per_cnt   <= '0;
            SEL       <= 1'b0;
            SEL_PULSE <= 1'b0;
            PRESS_CNT <= 8'd0;
        end else begin
            per_cnt   <= per_cnt_nxt;
            SEL       <= SEL ^ toggle;
            SEL_PULSE <= toggle;
            PRESS_CNT <= PRESS_CNT + {7'd0, press_accept};
        end
    end

endmodule

// File: tb/tb_mux_sel_ctrl.sv
// tb/tb_mux_sel_ctrl.sv - self-checking bench for mux_sel_ctrl

module tb_mux_sel_ctrl;

    localparam int DB = 4;
    localparam int AP = 10;

    logic       CLOCK_50;
    logic       RESET_N;
    logic       KEY_IN;
    logic       MODE;
    logic       SEL;
    logic       SEL_PULSE;
    logic [7:0] PRESS_CNT;

    int checks = 0;
    int errors = 0;

    mux_sel_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .AUTO_PERIOD    (AP),
        .CNT_W          (8)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .KEY_IN   (KEY_IN),
        .MODE     (MODE),
        .SEL      (SEL),
        .SEL_PULSE(SEL_PULSE),
        .PRESS_CNT(PRESS_CNT)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    // Reference model: the input seen by the decision logic lags the pin by
    // two edges; the debounced level flips after DB+1 consecutive opposite
    // samples; auto mode toggles after AP elapsed cycles of auto mode, a
    // press restarting that count.
    logic       h1k, h2k, h1m, h2m;
    logic       m_lvl;
    int         m_run;
    int         m_phase;
    logic       exp_sel;
    logic       exp_pulse;
    logic [7:0] exp_cnt;

    task automatic model_reset();
        h1k = 1'b1; h2k = 1'b1; h1m = 1'b0; h2m = 1'b0;
        m_lvl = 1'b1; m_run = 0; m_phase = 0;
        exp_sel = 1'b0; exp_pulse = 1'b0; exp_cnt = 8'd0;
    endtask

    task automatic step(input logic k, input logic m);
        logic vk, vm, press, expire;
        KEY_IN = k;
        MODE   = m;
        @(posedge CLOCK_50);
        if (!RESET_N) begin
            model_reset();
        end else begin
            vk = h2k; vm = h2m;
            h2k = h1k; h1k = k;
            h2m = h1m; h1m = m;
            press = 1'b0;
            expire = 1'b0;
            if (vk != m_lvl) begin
                m_run++;
                if (m_run == DB + 1) begin
                    m_lvl = vk;
                    m_run = 0;
                    press = (vk == 1'b0);
                end
            end else begin
                m_run = 0;
            end
            if (press) begin
                m_phase = 0;
            end else if (vm) begin
                m_phase++;
                if (m_phase == AP) begin
                    expire = 1'b1;
                    m_phase = 0;
                end
            end else begin
                m_phase = 0;
            end
            if (press || expire) exp_sel = ~exp_sel;
            exp_pulse = press || expire;
            if (press) exp_cnt = exp_cnt + 8'd1;
        end
        #1;
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        #3;
        RESET_N = 1'b1;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        KEY_IN  = 1'b1;
        MODE    = 1'b0;
        #2;
        model_reset();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        checks++;
        if ({SEL, SEL_PULSE, PRESS_CNT} !== 10'd0) begin
            errors++;
            $display("FAIL reset_state got sel=%b pulse=%b cnt=%0d want 0/0/0", SEL, SEL_PULSE, PRESS_CNT);
        end
        #3;
        RESET_N = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0);
            checks++;
            if ({SEL, SEL_PULSE, PRESS_CNT} !== {exp_sel, exp_pulse, exp_cnt}) begin
                errors++;
                $display("FAIL reset_idle got %b/%b/%0d want %b/%b/%0d", SEL, SEL_PULSE, PRESS_CNT, exp_sel, exp_pulse, exp_cnt);
            end
        end
    endtask

    task automatic test_press_latency();
        int first = -1;
        int pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0);
            checks++;
            if ({SEL, SEL_PULSE, PRESS_CNT} !== {exp_sel, exp_pulse, exp_cnt}) begin
                errors++;
                $display("FAIL press_model cyc %0d got %b/%b/%0d want %b/%b/%0d", i, SEL, SEL_PULSE, PRESS_CNT, exp_sel, exp_pulse, exp_cnt);
            end
            if (SEL_PULSE === 1'b1) pulses++;
            if (SEL === 1'b1 && first < 0) first = i;
        end
        // i counts edges from the first one that samples the low key (edge n)
        checks++;
        if (first !== DB + 2) begin
            errors++;
            $display("FAIL press_latency got edge n+%0d want n+%0d", first, DB + 2);
        end
        checks++;
        if (pulses !== 1 || PRESS_CNT !== 8'd1 || SEL !== 1'b1) begin
            errors++;
            $display("FAIL press_single got pulses=%0d cnt=%0d sel=%b want 1/1/1", pulses, PRESS_CNT, SEL);
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0);
            checks++;
            if ({SEL, SEL_PULSE, PRESS_CNT} !== {exp_sel, exp_pulse, exp_cnt}) begin
                errors++;
                $display("FAIL release_model cyc %0d got %b/%b/%0d want %b/%b/%0d", i, SEL, SEL_PULSE, PRESS_CNT, exp_sel, exp_pulse, exp_cnt);
            end
        end
    endtask

    task automatic test_bounce();
        logic       sel0 = SEL;
        logic [7:0] cnt0 = PRESS_CNT;
        int         pulses = 0;
        for (int i = 0; i < 12; i++) begin
            step((i < 2) ? 1'b0 : 1'b1, 1'b0);
            checks++;
            if ({SEL, SEL_PULSE, PRESS_CNT} !== {exp_sel, exp_pulse, exp_cnt}) begin
                errors++;
                $display("FAIL bounce_model cyc %0d got %b/%b/%0d want %b/%b/%0d", i, SEL, SEL_PULSE, PRESS_CNT, exp_sel, exp_pulse, exp_cnt);
            end
            if (SEL_PULSE === 1'b1) pulses++;
        end
        checks++;
        if (SEL !== sel0 || PRESS_CNT !== cnt0 || pulses !== 0) begin
            errors++;
            $display("FAIL bounce_reject got sel=%b cnt=%0d pulses=%0d want %b/%0d/0", SEL, PRESS_CNT, pulses, sel0, cnt0);
        end
    endtask

    task automatic test_wrap();
        int pulses = 0;
        do_reset();
        for (int p = 0; p < 256; p++) begin
            for (int i = 0; i < 16; i++) begin
                step((i < 8) ? 1'b0 : 1'b1, 1'b0);
                checks++;
                if ({SEL, SEL_PULSE, PRESS_CNT} !== {exp_sel, exp_pulse, exp_cnt}) begin
                    errors++;
                    $display("FAIL wrap_model press %0d cyc %0d got %b/%b/%0d want %b/%b/%0d", p, i, SEL, SEL_PULSE, PRESS_CNT, exp_sel, exp_pulse, exp_cnt);
                end
                if (SEL_PULSE === 1'b1) pulses++;
            end
        end
        checks++;
        if (pulses !== 256 || SEL !== 1'b0 || PRESS_CNT !== 8'd0) begin
            errors++;
            $display("FAIL wrap_total got pulses=%0d sel=%b cnt=%0d want 256/0/0", pulses, SEL, PRESS_CNT);
        end
    endtask

    task automatic test_auto();
        int first = -1;
        int last = -1;
        int pulses = 0;
        do_reset();
        for (int i = 1; i <= 45; i++) begin
            step(1'b1, 1'b1);
            checks++;
            if ({SEL, SEL_PULSE, PRESS_CNT} !== {exp_sel, exp_pulse, exp_cnt}) begin
                errors++;
                $display("FAIL auto_model cyc %0d got %b/%b/%0d want %b/%b/%0d", i, SEL, SEL_PULSE, PRESS_CNT, exp_sel, exp_pulse, exp_cnt);
            end
            if (SEL_PULSE === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
                if (last >= 0) begin
                    checks++;
                    if (i - last !== AP) begin
                        errors++;
                        $display("FAIL auto_period got %0d want %0d", i - last, AP);
                    end
                end
                last = i;
            end
        end
        // mode reaches the synchronised domain on the second edge
        checks++;
        if (first !== AP + 2 || pulses !== 4 || PRESS_CNT !== 8'd0) begin
            errors++;
            $display("FAIL auto_first got first=%0d pulses=%0d cnt=%0d want %0d/4/0", first, pulses, PRESS_CNT, AP + 2);
        end
    endtask

    task automatic test_collision();
        logic       sel0;
        logic [7:0] cnt0;
        int         guard = 0;
        int         pulses = 0;
        int         next = -1;
        // press accepted DB+3 steps after the key drops; line it up with expiry
        while ((AP - m_phase) != DB + 3 && guard < 3 * AP) begin
            step(1'b1, 1'b1);
            guard++;
        end
        checks++;
        if ((AP - m_phase) != DB + 3) begin
            errors++;
            $display("FAIL collision_align got phase=%0d want %0d", m_phase, AP - DB - 3);
        end
        sel0 = SEL;
        cnt0 = PRESS_CNT;
        for (int i = 1; i <= DB + 3; i++) begin
            step(1'b0, 1'b1);
            checks++;
            if ({SEL, SEL_PULSE, PRESS_CNT} !== {exp_sel, exp_pulse, exp_cnt}) begin
                errors++;
                $display("FAIL collision_model cyc %0d got %b/%b/%0d want %b/%b/%0d", i, SEL, SEL_PULSE, PRESS_CNT, exp_sel, exp_pulse, exp_cnt);
            end
            if (SEL_PULSE === 1'b1) pulses++;
        end
        checks++;
        if (SEL !== ~sel0 || SEL_PULSE !== 1'b1 || pulses !== 1 || PRESS_CNT !== cnt0 + 8'd1) begin
            errors++;
            $display("FAIL collision_single got sel=%b pulse=%b pulses=%0d cnt=%0d want %b/1/1/%0d", SEL, SEL_PULSE, pulses, PRESS_CNT, ~sel0, cnt0 + 8'd1);
        end
        for (int i = 1; i <= AP + 2; i++) begin
            step(1'b0, 1'b1);
            if (SEL_PULSE === 1'b1 && next < 0) next = i;
        end
        checks++;
        if (next !== AP) begin
            errors++;
            $display("FAIL collision_restart got %0d want %0d", next, AP);
        end
    endtask

    task automatic test_reset_mid();
        int first = -1;
        do_reset();
        for (int i = 0; i < 16; i++) step((i < 8) ? 1'b0 : 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
        checks++;
        if (SEL !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre got sel=%b want 1", SEL);
        end
        #2;
        RESET_N = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({SEL, SEL_PULSE, PRESS_CNT} !== 10'd0) begin
            errors++;
            $display("FAIL reset_mid_async got %b/%b/%0d want 0/0/0", SEL, SEL_PULSE, PRESS_CNT);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        #3;
        RESET_N = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0);
            checks++;
            if ({SEL, SEL_PULSE, PRESS_CNT} !== {exp_sel, exp_pulse, exp_cnt}) begin
                errors++;
                $display("FAIL reset_mid_model cyc %0d got %b/%b/%0d want %b/%b/%0d", i, SEL, SEL_PULSE, PRESS_CNT, exp_sel, exp_pulse, exp_cnt);
            end
            if (SEL === 1'b1 && first < 0) first = i;
        end
        checks++;
        if (first !== DB + 2 || PRESS_CNT !== 8'd1) begin
            errors++;
            $display("FAIL reset_mid_held got edge n+%0d cnt=%0d want n+%0d cnt=1", first, PRESS_CNT, DB + 2);
        end
    endtask

    task automatic test_random();
        logic k = 1'b1;
        logic m = 1'b0;
        int   run = 0;
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            if (run == 0) begin
                k = ~k;
                run = (($urandom % 4) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 12);
            end
            run--;
            if ($urandom_range(0, 149) == 0) m = ~m;
            step(k, m);
            checks++;
            if ({SEL, SEL_PULSE, PRESS_CNT} !== {exp_sel, exp_pulse, exp_cnt}) begin
                errors++;
                $display("FAIL random_model cyc %0d got %b/%b/%0d want %b/%b/%0d", i, SEL, SEL_PULSE, PRESS_CNT, exp_sel, exp_pulse, exp_cnt);
            end
        end
    endtask

    initial begin
        RESET_N = 1'b0;
        KEY_IN  = 1'b1;
        MODE    = 1'b0;
        model_reset();
        test_reset();
        test_press_latency();
        test_bounce();
        test_wrap();
        test_auto();
        test_collision();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
